// File: rtl/jelly2_necolink_pkg.sv
// Shared constants and types for necolink CRC-32 generation and checking.
package jelly2_necolink_pkg;

  localparam logic [31:0] CRC32_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_FINAL_XOR = 32'hFFFFFFFF;
  // CRC register value left after running a good frame including its FCS.
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    ByteKindPass,
    ByteKindCrc,
    ByteKindFcs
  } byte_kind_t;

endpackage

// File: rtl/jelly2_necolink_crc32_byte.sv
// Byte-serial reflected CRC-32 update (LSB of the data byte first).
module jelly2_necolink_crc32_byte
  import jelly2_necolink_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  always_comb begin
    o_crc = i_crc;
    for (int i = 0; i < 8; i++) begin
      o_crc = (o_crc >> 1) ^ (((o_crc[0] ^ i_data[i]) != 1'b0) ? CRC32_POLY : 32'h0);
    end
  end

endmodule

// File: rtl/jelly2_necolink_packet_fcs_inserter.sv
// Accumulates CRC-32 over flagged bytes and overwrites the reserved FCS bytes
// with the final FCS, LSB first, producing a plain first/last byte stream.
module jelly2_necolink_packet_fcs_inserter
  import jelly2_necolink_pkg::*;
#(
  parameter bit          DEBUG      = 1'b0,
  parameter bit          SIMULATION = 1'b0,
  parameter int unsigned FCS_BYTES  = 4
) (
  input  logic        reset,
  input  logic        clk,
  input  logic        cke,

  input  logic        s_packet_first,
  input  logic        s_packet_last,
  input  logic        s_packet_crc,
  input  logic        s_packet_crc_first,
  input  logic        s_packet_fcs,
  input  logic        s_packet_fcs_first,
  input  logic [7:0]  s_packet_data,
  input  logic        s_packet_valid,
  output logic        s_packet_ready,

  output logic        m_tx_first,
  output logic        m_tx_last,
  output logic [7:0]  m_tx_data,
  output logic        m_tx_valid,
  input  logic        m_tx_ready,

  output logic        fcs_error,
  output logic [31:0] crc_value
);

  localparam int unsigned     CntW     = $clog2(FCS_BYTES + 1);
  localparam logic [CntW-1:0] FcsBytes = CntW'(FCS_BYTES);

  logic            r_valid;
  logic            r_first;
  logic            r_last;
  logic [7:0]      r_data;
  logic            r_fcs_error;
  logic [31:0]     r_crc;
  logic [31:0]     r_fcs_reg;
  logic [CntW-1:0] r_fcs_count;

  logic            w_local_cke;
  logic            w_accept;
  byte_kind_t      w_kind;
  logic [31:0]     w_crc_base;
  logic [31:0]     w_crc_upd;
  logic [31:0]     w_fcs_value;
  logic [31:0]     w_crc_next;
  logic [31:0]     w_fcs_reg_next;
  logic [CntW-1:0] w_fcs_count_next;
  logic [7:0]      w_data_next;
  logic            w_error;

  assign w_local_cke    = !r_valid || m_tx_ready;
  assign s_packet_ready = cke && w_local_cke;
  assign w_accept       = s_packet_valid && s_packet_ready;
  assign w_crc_base     = s_packet_crc_first ? CRC32_INIT : r_crc;
  assign w_fcs_value    = r_crc ^ CRC32_FINAL_XOR;

  jelly2_necolink_crc32_byte u_crc32_byte (
    .i_crc  (w_crc_base),
    .i_data (s_packet_data),
    .o_crc  (w_crc_upd)
  );

  always_comb begin
    w_kind = ByteKindPass;
    if (s_packet_fcs) begin
      w_kind = ByteKindFcs;
    end else if (s_packet_crc) begin
      w_kind = ByteKindCrc;
    end

    w_data_next      = s_packet_data;
    w_crc_next       = r_crc;
    w_fcs_reg_next   = r_fcs_reg;
    w_fcs_count_next = r_fcs_count;
    w_error          = 1'b0;

    unique case (w_kind)
      ByteKindFcs: begin
        if (s_packet_fcs_first) begin
          w_data_next      = w_fcs_value[7:0];
          w_fcs_reg_next   = w_fcs_value >> 8;
          w_fcs_count_next = CntW'(1);
        end else if ((r_fcs_count == '0) || (r_fcs_count >= FcsBytes)) begin
          // Out-of-sequence FCS byte: blank it and leave the count alone.
          w_data_next = 8'h00;
          w_error     = 1'b1;
        end else begin
          w_data_next      = r_fcs_reg[7:0];
          w_fcs_reg_next   = r_fcs_reg >> 8;
          w_fcs_count_next = r_fcs_count + CntW'(1);
        end
      end
      ByteKindCrc: w_crc_next = w_crc_upd;
      default: ;
    endcase

    if (s_packet_last) begin
      if (w_fcs_count_next != FcsBytes) begin
        w_error = 1'b1;
      end
      w_fcs_count_next = '0;
      w_crc_next       = CRC32_INIT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
      r_data      <= 8'h00;
      r_fcs_error <= 1'b0;
      r_crc       <= CRC32_INIT;
      r_fcs_reg   <= 32'h0;
      r_fcs_count <= '0;
    end else if (cke) begin
      r_fcs_error <= w_accept && w_error;
      if (w_local_cke) begin
        r_valid <= s_packet_valid;
        if (s_packet_valid) begin
          r_first     <= s_packet_first;
          r_last      <= s_packet_last;
          r_data      <= w_data_next;
          r_crc       <= w_crc_next;
          r_fcs_reg   <= w_fcs_reg_next;
          r_fcs_count <= w_fcs_count_next;
        end
      end
    end
  end

  assign m_tx_first = r_first;
  assign m_tx_last  = r_last;
  assign m_tx_data  = r_data;
  assign m_tx_valid = r_valid;
  assign fcs_error  = r_fcs_error;

  if (DEBUG) begin : g_debug
    (* mark_debug = "true" *) logic [31:0] w_crc_dbg;
    assign w_crc_dbg = r_crc;
    assign crc_value = w_crc_dbg;
  end else begin : g_nodebug
    assign crc_value = r_crc;
  end

  if (SIMULATION) begin : g_sim
    // Set once a CRC-covered byte has gone by in the current packet.
    logic r_seen_crc;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_seen_crc <= 1'b0;
      end else if (w_accept) begin
        if (s_packet_last) begin
          r_seen_crc <= 1'b0;
        end else if (s_packet_first) begin
          r_seen_crc <= s_packet_crc && !s_packet_fcs;
        end else if (s_packet_crc && !s_packet_fcs) begin
          r_seen_crc <= 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!reset && w_accept && s_packet_fcs) begin
        assert (r_seen_crc);
      end
    end
  end

endmodule

// File: tb/tb_jelly2_necolink_packet_fcs_inserter.sv
// Bench for the FCS inserter: table of known CRC vectors, hand-written corner
// sequences and randomized packets checked against a queue-based model.
module tb_jelly2_necolink_packet_fcs_inserter;

  localparam int FcsN = 4;

  logic        reset;
  logic        clk;
  logic        cke;
  logic        s_packet_first;
  logic        s_packet_last;
  logic        s_packet_crc;
  logic        s_packet_crc_first;
  logic        s_packet_fcs;
  logic        s_packet_fcs_first;
  logic [7:0]  s_packet_data;
  logic        s_packet_valid;
  logic        s_packet_ready;
  logic        m_tx_first;
  logic        m_tx_last;
  logic [7:0]  m_tx_data;
  logic        m_tx_valid;
  logic        m_tx_ready = 1'b1;
  logic        fcs_error;
  logic [31:0] crc_value;

  jelly2_necolink_packet_fcs_inserter #(
    .DEBUG      (1'b0),
    .SIMULATION (1'b1),
    .FCS_BYTES  (FcsN)
  ) u_dut (
    .reset              (reset),
    .clk                (clk),
    .cke                (cke),
    .s_packet_first     (s_packet_first),
    .s_packet_last      (s_packet_last),
    .s_packet_crc       (s_packet_crc),
    .s_packet_crc_first (s_packet_crc_first),
    .s_packet_fcs       (s_packet_fcs),
    .s_packet_fcs_first (s_packet_fcs_first),
    .s_packet_data      (s_packet_data),
    .s_packet_valid     (s_packet_valid),
    .s_packet_ready     (s_packet_ready),
    .m_tx_first         (m_tx_first),
    .m_tx_last          (m_tx_last),
    .m_tx_data          (m_tx_data),
    .m_tx_valid         (m_tx_valid),
    .m_tx_ready         (m_tx_ready),
    .fcs_error          (fcs_error),
    .crc_value          (crc_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       first;
    logic       last;
    logic       crc;
    logic       crc_first;
    logic       fcs;
    logic       fcs_first;
    logic [7:0] data;
  } in_byte_t;

  typedef struct packed {
    logic       first;
    logic       last;
    logic [7:0] data;
  } out_byte_t;

  typedef struct packed {
    logic [3:0]  len;
    logic [71:0] pl;
    logic [31:0] fcs;
  } vec_t;

  int          n_vec;
  int          n_bad;
  in_byte_t    pkt[$];
  out_byte_t   exp_q[$];
  out_byte_t   act_q[$];
  int          exp_err;
  int          act_err;
  bit          rdy_rand;
  int          gap_pct;
  logic [31:0] last_fcs;
  vec_t        vt[4];
  logic [7:0]  pl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Textbook reflected CRC-32 register over a byte list (before final inversion).
  function automatic logic [31:0] crc32_raw(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return c;
  endfunction

  function automatic void add_pkt(input logic [7:0] p[$], input int nfcs);
    in_byte_t b;
    for (int i = 0; i < 8; i++) begin
      b = '0;
      b.first = (i == 0);
      b.data  = (i == 7) ? 8'hD5 : 8'h55;
      pkt.push_back(b);
    end
    for (int i = 0; i < p.size(); i++) begin
      b = '0;
      b.crc       = 1'b1;
      b.crc_first = (i == 0);
      b.data      = p[i];
      pkt.push_back(b);
    end
    for (int i = 0; i < nfcs; i++) begin
      b = '0;
      b.fcs       = 1'b1;
      b.fcs_first = (i == 0);
      b.last      = (i == nfcs - 1);
      b.data      = 8'($urandom);
      pkt.push_back(b);
    end
  endfunction

  // Expected output stream: FCS = ~CRC over covered bytes, emitted LSB first.
  function automatic void build_exp();
    logic [7:0]  cov[$];
    logic [31:0] fcs;
    int          k;
    bit          err;
    out_byte_t   o;
    fcs = 32'h0;
    k = 0;
    exp_q.delete();
    exp_err = 0;
    foreach (pkt[i]) begin
      o.first = pkt[i].first;
      o.last  = pkt[i].last;
      o.data  = pkt[i].data;
      err = 1'b0;
      if (pkt[i].fcs) begin
        if (pkt[i].fcs_first) begin
          fcs = ~crc32_raw(cov);
          k = 0;
        end
        if (pkt[i].fcs_first || (k > 0 && k < FcsN)) begin
          o.data = fcs[8*k +: 8];
          k++;
        end else begin
          o.data = 8'h00;
          err = 1'b1;
        end
      end else if (pkt[i].crc) begin
        if (pkt[i].crc_first) cov.delete();
        cov.push_back(pkt[i].data);
      end
      if (pkt[i].last) begin
        if (k != FcsN) err = 1'b1;
        k = 0;
        cov.delete();
      end
      if (err) exp_err++;
      exp_q.push_back(o);
    end
  endfunction

  task automatic drive_byte(input in_byte_t b, input bit stall, input bit chk_crc,
                            input logic [31:0] crc_exp);
    logic        acc;
    logic [42:0] snap;
    s_packet_valid     = 1'b1;
    s_packet_first     = b.first;
    s_packet_last      = b.last;
    s_packet_crc       = b.crc;
    s_packet_crc_first = b.crc_first;
    s_packet_fcs       = b.fcs;
    s_packet_fcs_first = b.fcs_first;
    s_packet_data      = b.data;
    if (stall) begin
      cke = 1'b0;
      @(negedge clk);
      snap = {m_tx_valid, m_tx_first, m_tx_last, m_tx_data, crc_value};
      for (int k = 0; k < 5; k++) begin
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("cke_ready", 64'(s_packet_ready), 64'(0));
        chk("cke_frozen", 64'({m_tx_valid, m_tx_first, m_tx_last, m_tx_data, crc_value}),
            64'(snap));
      end
      @(posedge clk);
      #1;
      cke = 1'b1;
    end
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (t == 0 && chk_crc) chk("crc_before_fcs", 64'(crc_value), 64'(crc_exp));
      acc = s_packet_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      if (t >= 300) begin
        chk("accept_timeout", 64'(acc), 64'(1));
        break;
      end
    end
    s_packet_valid = 1'b0;
  endtask

  task automatic run_pkt(input string tag, input int stall_at);
    logic [7:0] cov[$];
    int         t;
    int         n;
    build_exp();
    act_err = 0;
    for (int i = 0; i < pkt.size(); i++) begin
      bit is_fcs0;
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        s_packet_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      if (pkt[i].crc && !pkt[i].fcs && pkt[i].crc_first) cov.delete();
      is_fcs0 = pkt[i].fcs && pkt[i].fcs_first;
      drive_byte(pkt[i], i == stall_at, is_fcs0, crc32_raw(cov));
      if (pkt[i].crc && !pkt[i].fcs) cov.push_back(pkt[i].data);
      if (pkt[i].last) cov.delete();
    end
    t = 0;
    while (act_q.size() < exp_q.size() && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk($sformatf("%s_count", tag), 64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), 64'(act_q[i]), 64'(exp_q[i]));
    end
    chk($sformatf("%s_fcs_error", tag), 64'(act_err), 64'(exp_err));
    n = act_q.size();
    last_fcs = (n >= 4) ? {act_q[n-1].data, act_q[n-2].data, act_q[n-3].data, act_q[n-4].data}
                        : 32'h0;
    pkt.delete();
    exp_q.delete();
    act_q.delete();
  endtask

  always @(posedge clk) begin
    #1;
    m_tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: collects transfers, counts error pulses, checks stall stability.
  logic [10:0] prev_o;
  bit          prev_hold = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("stall_stable", 64'({m_tx_valid, m_tx_first, m_tx_last, m_tx_data}), 64'(prev_o));
      end
      if (fcs_error) act_err++;
      if (cke && m_tx_valid && m_tx_ready) act_q.push_back({m_tx_first, m_tx_last, m_tx_data});
      prev_hold = m_tx_valid && !(cke && m_tx_ready);
      prev_o    = {m_tx_valid, m_tx_first, m_tx_last, m_tx_data};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    rdy_rand = 1'b0;
    gap_pct = 0;
    cke = 1'b1;
    reset = 1'b1;
    s_packet_valid = 1'b0;
    s_packet_first = 1'b0;
    s_packet_last = 1'b0;
    s_packet_crc = 1'b0;
    s_packet_crc_first = 1'b0;
    s_packet_fcs = 1'b0;
    s_packet_fcs_first = 1'b0;
    s_packet_data = 8'h00;

    vt[0] = '{len: 4'd9, pl: 72'h393837363534333231, fcs: 32'hCBF43926};
    vt[1] = '{len: 4'd1, pl: 72'h0,                  fcs: 32'hD202EF8D};
    vt[2] = '{len: 4'd1, pl: 72'h61,                 fcs: 32'hE8B7BE43};
    vt[3] = '{len: 4'd3, pl: 72'h636261,             fcs: 32'h352441C2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(m_tx_valid), 64'(0));
    chk("rst_fcs_error", 64'(fcs_error), 64'(0));
    chk("rst_crc", 64'(crc_value), 64'(32'hFFFFFFFF));
    chk("rst_first_last", 64'({m_tx_first, m_tx_last}), 64'(0));
    chk("rst_data", 64'(m_tx_data), 64'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_ready", 64'(s_packet_ready), 64'(1));

    // One-cycle latency, then valid drops when idle.
    s_packet_valid = 1'b1;
    s_packet_first = 1'b1;
    s_packet_data  = 8'h55;
    @(posedge clk);
    #1;
    s_packet_valid = 1'b0;
    s_packet_first = 1'b0;
    chk("lat_out", 64'({m_tx_valid, m_tx_first, m_tx_last, m_tx_data}),
        64'({1'b1, 1'b1, 1'b0, 8'h55}));
    @(posedge clk);
    #1;
    chk("idle_drop", 64'(m_tx_valid), 64'(0));
    act_q.delete();

    // Known-answer table: clean pass, then random ready and valid gaps.
    for (int pass = 0; pass < 2; pass++) begin
      rdy_rand = (pass == 1);
      gap_pct  = (pass == 1) ? 30 : 0;
      for (int i = 0; i < 4; i++) begin
        pl.delete();
        for (int b = 0; b < int'(vt[i].len); b++) pl.push_back(vt[i].pl[8*b +: 8]);
        add_pkt(pl, FcsN);
        run_pkt($sformatf("tbl%0d_%0d", pass, i), -1);
        chk($sformatf("tbl%0d_%0d_fcs", pass, i), 64'(last_fcs), 64'(vt[i].fcs));
      end
    end

    // Back-to-back packets, second with a single zero byte.
    rdy_rand = 1'b0;
    gap_pct = 0;
    pl.delete();
    for (int b = 0; b < 9; b++) pl.push_back(vt[0].pl[8*b +: 8]);
    add_pkt(pl, FcsN);
    pl.delete();
    pl.push_back(8'h00);
    add_pkt(pl, FcsN);
    run_pkt("b2b", -1);
    chk("b2b_fcs2", 64'(last_fcs), 64'(32'hD202EF8D));

    // Five FCS bytes: the extra one is blanked and flagged once.
    pl.delete();
    for (int b = 0; b < 3; b++) pl.push_back(vt[3].pl[8*b +: 8]);
    add_pkt(pl, 5);
    run_pkt("fcs5", -1);
    chk("fcs5_err_count", 64'(act_err), 64'(1));
    chk("fcs5_extra_byte", 64'(last_fcs[31:24]), 64'(0));

    // Packet ends after three FCS bytes.
    add_pkt(pl, 3);
    run_pkt("fcs3", -1);
    chk("fcs3_err_count", 64'(act_err), 64'(1));

    // cke held low mid-payload.
    pl.delete();
    for (int b = 0; b < 9; b++) pl.push_back(vt[0].pl[8*b +: 8]);
    add_pkt(pl, FcsN);
    run_pkt("cke", 12);
    chk("cke_fcs", 64'(last_fcs), 64'(32'hCBF43926));

    // Asynchronous reset mid-payload, then a clean packet.
    add_pkt(pl, FcsN);
    for (int i = 0; i < 12; i++) drive_byte(pkt[i], 1'b0, 1'b0, 32'h0);
    chk("pre_reset_valid", 64'(m_tx_valid), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_valid", 64'(m_tx_valid), 64'(0));
    chk("async_reset_crc", 64'(crc_value), 64'(32'hFFFFFFFF));
    @(posedge clk);
    #1;
    reset = 1'b0;
    pkt.delete();
    exp_q.delete();
    act_q.delete();
    add_pkt(pl, FcsN);
    run_pkt("post_reset", -1);
    chk("post_reset_fcs", 64'(last_fcs), 64'(32'hCBF43926));

    // Randomized packets against the model.
    rdy_rand = 1'b1;
    gap_pct = 25;
    for (int r = 0; r < 25; r++) begin
      pl.delete();
      for (int b = 0; b < int'($urandom_range(1, 16)); b++) pl.push_back(8'($urandom));
      add_pkt(pl, FcsN);
      if ($urandom_range(0, 2) == 0) begin
        pl.delete();
        for (int b = 0; b < int'($urandom_range(1, 6)); b++) pl.push_back(8'($urandom));
        add_pkt(pl, FcsN);
      end
      run_pkt($sformatf("rnd%0d", r), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
